psram_line_bridge: RTL and testbench
====================================

Name: psram_line_bridge

Overview:
- Sits between the cache-line side of ramio and the PSRAM_Memory_Interface_HS_V2_Top burst port, clocked by br_clk_out.
- Converts one cache-line request (32 bytes) into a single PSRAM burst command.
- Serializes a write line into 4 x 64-bit beats; deserializes read beats back into a line.
- Enforces the controller's minimum command spacing and bounds read latency with a timeout.

Parameters:
- AddressBitWidth, 21, width of br_addr and line_addr (byte address).
- BeatBitWidth, 64, width of one burst beat.
- BurstBeats, 4, beats per line; line width = BeatBitWidth*BurstBeats.
- CommandIntervalCycles, 18, minimum cycles from one br_cmd_en to the next.
- ReadTimeoutCycles, 64, maximum cycles from read br_cmd_en to the final read beat.

Ports:
- clk  in  1  br_clk_out domain clock.
- rst_n  in  1  asynchronous active-low reset.
- line_req  in  1  single-cycle request strobe; accepted only when busy=0.
- line_we  in  1  1: write line, 0: read line; sampled with line_req.
- line_addr  in  AddressBitWidth  byte address of the line; low 5 bits ignored.
- line_wr_data  in  256  write line; beat0 = bits[63:0]; sampled with line_req.
- line_rd_data  out  256  read line; beat0 = bits[63:0].
- line_done  out  1  single-cycle completion pulse.
- line_error  out  1  valid with line_done; 1 = read timed out.
- busy  out  1  high from acceptance until the next request may be accepted.
- br_cmd  out  1  0: read, 1: write.
- br_cmd_en  out  1  command strobe.
- br_addr  out  AddressBitWidth  burst start address.
- br_wr_data  out  BeatBitWidth  write beat.
- br_data_mask  out  8  tied to 0.
- br_rd_data  in  BeatBitWidth  read beat.
- br_rd_data_valid  in  1  read beat valid.

Behaviour:
- Reset:
  - Interface: single clock; reset asynchronous, active-low.
  - All outputs reset to 0, line_rd_data included; state returns to IDLE.
  - Reset mid-burst abandons the transfer; no line_done is issued.
- States: IDLE, WRITE, READ, COOLDOWN.
- IDLE:
  - line_req=1 latches line_we, line_addr and line_wr_data.
  - busy rises the next cycle (T).
  - At T, br_cmd_en=1, br_cmd=line_we, br_addr={line_addr[20:5],5'b0}.
  - Write: br_wr_data=beat0 at T; next state WRITE.
  - Read: next state READ.
- WRITE:
  - Beats 1..3 are driven on T+1..T+3, back-to-back.
  - line_done=1 with line_error=0 at T+4; then COOLDOWN.
- READ:
  - Each br_rd_data_valid cycle stores br_rd_data into the next beat slot (slot counter 0..3).
  - On the cycle after the 4th beat: line_done=1, line_error=0, then COOLDOWN.
  - line_rd_data is updated only as beats arrive and is held until the next read's first beat.
  - Timeout: if the 4th beat has not arrived by T+ReadTimeoutCycles, pulse line_done=1 with line_error=1 and go to COOLDOWN. Partial data stays in line_rd_data.
- COOLDOWN:
  - Held until CommandIntervalCycles have elapsed since T, i.e. the next br_cmd_en is no earlier than T+CommandIntervalCycles.
  - busy falls on the cycle the state returns to IDLE.
  - If the transfer itself outlasts the interval, COOLDOWN lasts 1 cycle.
- Counters:
  - Interval counter: free-running from T, saturating, width clog2(max(CommandIntervalCycles, ReadTimeoutCycles)+1).
  - Beat counter: 2 bits; wraps only on reset or new request.
- Ignored inputs:
  - br_rd_data_valid outside READ, or after 4 beats, is ignored.
  - line_req while busy=1 is ignored; line_req on the same cycle busy falls is ignored.
- br_cmd_en is exactly one cycle per accepted request.
- br_wr_data holds its last beat outside WRITE.

Decomposition:
- configuration package holds PSRAM_COMMAND_INTERVAL_CYCLES, PSRAM_READ_TIMEOUT_CYCLES and LINE_BIT_WIDTH (256).
- The state enum is local to the module.
- No sub-module; beat shift/assemble logic is inline.

Test Plan:
- Write request:
  - Stimulus: line_req, we=1, addr=0x00_1234, data beats {A0..A3}.
  - Response: br_cmd_en at T with br_addr=0x00_1220; beats A0..A3 on T..T+3; line_done at T+4; busy low at T+18.
- Read request:
  - Stimulus: read at 0x00_0040; valid beats B0..B3 at T+9, T+10, T+12, T+13.
  - Response: line_done at T+14; line_rd_data={B3,B2,B1,B0}; line_error=0.
- Timeout:
  - Stimulus: read with only 2 valid beats.
  - Response: line_done with line_error=1 at T+64; slots 0..1 updated; busy low at T+65.
- Back-to-back requests:
  - Stimulus: second line_req issued every cycle while busy.
  - Response: ignored until busy=0; consecutive br_cmd_en spaced ≥18 cycles.
- Reset mid-operation:
  - Stimulus: rst_n low at T+2 of a write.
  - Response: all outputs 0 immediately; no line_done; next request proceeds normally.
- Stray beat:
  - Stimulus: br_rd_data_valid pulse in IDLE, then a read.
  - Response: the stray beat is not captured; the read's beat0 lands in bits[63:0].

Source files
------------

// File: rtl/psram_line_bridge_pkg.sv
// Shared configuration for the cache-line to PSRAM burst bridge.
package psram_line_bridge_pkg;

    localparam int unsigned ADDRESS_BIT_WIDTH             = 21;
    localparam int unsigned BEAT_BIT_WIDTH                = 64;
    localparam int unsigned BURST_BEATS                   = 4;
    localparam int unsigned LINE_BIT_WIDTH                = 256;
    localparam int unsigned PSRAM_COMMAND_INTERVAL_CYCLES = 18;
    localparam int unsigned PSRAM_READ_TIMEOUT_CYCLES     = 64;

endpackage

// File: rtl/psram_line_bridge.sv
// Converts one 32-byte cache-line request into a single PSRAM burst command,
// serializing write lines and reassembling read beats, with command spacing
// and a bounded read latency.
module psram_line_bridge
    import psram_line_bridge_pkg::*;
#(
    parameter int unsigned AddressBitWidth       = ADDRESS_BIT_WIDTH,
    parameter int unsigned BeatBitWidth          = BEAT_BIT_WIDTH,
    parameter int unsigned BurstBeats            = BURST_BEATS,
    parameter int unsigned CommandIntervalCycles = PSRAM_COMMAND_INTERVAL_CYCLES,
    parameter int unsigned ReadTimeoutCycles     = PSRAM_READ_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       line_req,
    input  logic                       line_we,
    input  logic [AddressBitWidth-1:0] line_addr,
    input  logic [LINE_BIT_WIDTH-1:0]  line_wr_data,
    output logic [LINE_BIT_WIDTH-1:0]  line_rd_data,
    output logic                       line_done,
    output logic                       line_error,
    output logic                       busy,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [AddressBitWidth-1:0] br_addr,
    output logic [BeatBitWidth-1:0]    br_wr_data,
    output logic [7:0]                 br_data_mask,
    input  logic [BeatBitWidth-1:0]    br_rd_data,
    input  logic                       br_rd_data_valid
);

    localparam int unsigned MaxCycles = (CommandIntervalCycles > ReadTimeoutCycles) ?
                                        CommandIntervalCycles : ReadTimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned ShiftW    = LINE_BIT_WIDTH - BeatBitWidth;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        READ     = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [1:0]                 beat_q, beat_d;
    logic                       cmd_en_q, cmd_en_d;
    logic                       cmd_q, cmd_d;
    logic [AddressBitWidth-1:0] addr_q, addr_d;
    logic [BeatBitWidth-1:0]    wr_data_q, wr_data_d;
    logic [ShiftW-1:0]          wr_shift_q, wr_shift_d;
    logic [LINE_BIT_WIDTH-1:0]  rd_line_q, rd_line_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       last_beat_c;

    // A valid beat landing in the final slot completes the read.
    assign last_beat_c = br_rd_data_valid && (beat_q == 2'(BurstBeats - 1));

    // Next-state and next-output logic; strobes default low, data holds.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        beat_d     = beat_q;
        cmd_en_d   = 1'b0;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        wr_shift_d = wr_shift_q;
        rd_line_d  = rd_line_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_req && !busy_q) begin
                    busy_d   = 1'b1;
                    cmd_en_d = 1'b1;
                    cmd_d    = line_we;
                    addr_d   = line_addr & ~AddressBitWidth'(31);
                    cnt_d    = '0;
                    beat_d   = '0;
                    if (line_we) begin
                        wr_data_d  = line_wr_data[BeatBitWidth-1:0];
                        wr_shift_d = line_wr_data[LINE_BIT_WIDTH-1:BeatBitWidth];
                        state_d    = WRITE;
                    end else begin
                        state_d    = READ;
                    end
                end
            end

            WRITE: begin
                if (beat_q == 2'(BurstBeats - 1)) begin
                    done_d  = 1'b1;
                    state_d = COOLDOWN;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    wr_data_d  = wr_shift_q[BeatBitWidth-1:0];
                    wr_shift_d = wr_shift_q >> BeatBitWidth;
                end
            end

            READ: begin
                if (br_rd_data_valid) begin
                    rd_line_d[int'(beat_q) * BeatBitWidth +: BeatBitWidth] = br_rd_data;
                    if (last_beat_c) begin
                        done_d  = 1'b1;
                        state_d = COOLDOWN;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                    end
                end
                if (!last_beat_c && (cnt_q == CntW'(ReadTimeoutCycles - 1))) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = COOLDOWN;
                end
            end

            COOLDOWN: begin
                if (cnt_q >= CntW'(CommandIntervalCycles - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            beat_q     <= '0;
            cmd_en_q   <= 1'b0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_shift_q <= '0;
            rd_line_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            cmd_en_q   <= cmd_en_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            wr_shift_q <= wr_shift_d;
            rd_line_q  <= rd_line_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign line_rd_data = rd_line_q;
    assign line_done    = done_q;
    assign line_error   = err_q;
    assign busy         = busy_q;
    assign br_cmd       = cmd_q;
    assign br_cmd_en    = cmd_en_q;
    assign br_addr      = addr_q;
    assign br_wr_data   = wr_data_q;
    assign br_data_mask = 8'h00;

endmodule

// File: tb/tb_psram_line_bridge.sv
// Bench for psram_line_bridge: directed vector table plus randomized transfers
// checked cycle by cycle against a timeline model of the bridge.
module tb_psram_line_bridge;

    localparam int unsigned AW = 21;
    localparam int unsigned BW = 64;
    localparam int unsigned LW = 256;
    localparam int unsigned NT = 128;
    localparam int INTERVAL    = 18;
    localparam int TIMEOUT     = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_req;
    logic          line_we;
    logic [AW-1:0] line_addr;
    logic [LW-1:0] line_wr_data;
    logic [LW-1:0] line_rd_data;
    logic          line_done;
    logic          line_error;
    logic          busy;
    logic          br_cmd;
    logic          br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [BW-1:0] br_wr_data;
    logic [7:0]    br_data_mask;
    logic [BW-1:0] br_rd_data;
    logic          br_rd_data_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [LW-1:0] model_rd;
    logic [BW-1:0] model_wr_last;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [NT-1:0] mask;
        logic          hammer;
        logic          stray;
        int            done_t;
        logic          err;
        int            idle_t;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl[8];

    psram_line_bridge dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .line_req         (line_req),
        .line_we          (line_we),
        .line_addr        (line_addr),
        .line_wr_data     (line_wr_data),
        .line_rd_data     (line_rd_data),
        .line_done        (line_done),
        .line_error       (line_error),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp, input int t);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] r256();
        return {r64(), r64(), r64(), r64()};
    endfunction

    function automatic logic [NT-1:0] mk(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
        logic [NT-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        if (e >= 0) m[e] = 1'b1;
        if (f >= 0) m[f] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mkv(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                                 input logic [NT-1:0] mask, input logic hammer, input logic stray,
                                 input int done_t, input logic err, input int idle_t,
                                 input logic [AW-1:0] exp_addr);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.mask = mask; v.hammer = hammer;
        v.stray = stray; v.done_t = done_t; v.err = err; v.idle_t = idle_t; v.exp_addr = exp_addr;
        return v;
    endfunction

    // Timeline rules: writes finish 4 cycles after the command; reads finish the cycle
    // after the 4th valid beat, or time out at 64; the bridge idles no sooner than 18.
    task automatic model(input logic we, input logic [NT-1:0] m,
                         output int done_t, output logic err, output int idle_t);
        int cnt;
        cnt = 0;
        if (we) begin
            done_t = 4;
            err    = 1'b0;
        end else begin
            done_t = TIMEOUT;
            err    = 1'b1;
            for (int t = 0; t < TIMEOUT; t++) begin
                if (m[t]) begin
                    cnt++;
                    if (cnt == 4) begin
                        done_t = t + 1;
                        err    = 1'b0;
                        break;
                    end
                end
            end
        end
        idle_t = (done_t + 1 > INTERVAL) ? done_t + 1 : INTERVAL;
    endtask

    // One accepted request followed cycle by cycle until the bridge is idle again.
    task automatic run_txn(input vec_t v);
        int k;
        k = 0;
        if (v.stray) begin
            br_rd_data_valid = 1'b1;
            br_rd_data       = r64();
        end
        chk("busy_before_req", busy, 0, -1);
        line_req     = 1'b1;
        line_we      = v.we;
        line_addr    = v.addr;
        line_wr_data = v.data;
        step();
        line_req         = 1'b0;
        br_rd_data_valid = 1'b0;
        for (int t = 0; t <= v.idle_t; t++) begin
            chk("br_cmd_en", br_cmd_en, (t == 0), t);
            chk("busy", busy, (t < v.idle_t), t);
            chk("line_done", line_done, (t == v.done_t), t);
            chk("line_error", line_error, (t == v.done_t) && v.err, t);
            chk("line_rd_data", line_rd_data, model_rd, t);
            if (v.we)
                chk("br_wr_data", br_wr_data, v.data[((t < 4) ? t : 3) * BW +: BW], t);
            else
                chk("br_wr_data_hold", br_wr_data, model_wr_last, t);
            if (t == 0) begin
                chk("br_cmd", br_cmd, v.we, t);
                chk("br_addr", br_addr, v.exp_addr, t);
                chk("br_data_mask", br_data_mask, 0, t);
            end
            if (t == v.idle_t) break;
            br_rd_data_valid = v.mask[t];
            br_rd_data       = r64();
            if (v.mask[t] && !v.we && k < 4 && t < v.done_t) begin
                br_rd_data = v.data[k * BW +: BW];
                model_rd[k * BW +: BW] = br_rd_data;
                k++;
            end
            if (v.hammer) begin
                line_req     = 1'b1;
                line_we      = 1'($urandom);
                line_addr    = AW'($urandom);
                line_wr_data = r256();
            end
            step();
        end
        line_req         = 1'b0;
        br_rd_data_valid = 1'b0;
        if (v.we) model_wr_last = v.data[LW-1 -: BW];
    endtask

    // Consecutive command strobes must be at least the command interval apart.
    int  cyc = 0;
    int  last_en = 0;
    bit  have_last = 0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_last = 0;
        end else if (br_cmd_en) begin
            if (have_last) chk("cmd_spacing_ok", (cyc - last_en) >= INTERVAL, 1, cyc - last_en);
            have_last = 1;
            last_en   = cyc;
        end
    end

    initial begin
        vec_t          v;
        logic [LW-1:0] beats_a, beats_b, beats_c;
        int            p;

        rst_n = 1'b1;
        line_req = 1'b0; line_we = 1'b0; line_addr = '0; line_wr_data = '0;
        br_rd_data = '0; br_rd_data_valid = 1'b0;
        model_rd = '0; model_wr_last = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0, 0);
        chk("rst_cmd_en", br_cmd_en, 0, 0);
        chk("rst_done", line_done, 0, 0);
        chk("rst_rd_data", line_rd_data, 0, 0);
        chk("rst_wr_data", br_wr_data, 0, 0);
        chk("rst_addr", br_addr, 0, 0);
        rst_n = 1'b1;
        step();

        beats_a = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                   64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        beats_b = {64'hB3B3_0000_1111_0003, 64'hB2B2_0000_1111_0002,
                   64'hB1B1_0000_1111_0001, 64'hB0B0_0000_1111_0000};
        beats_c = {64'hC3C3_5555_AAAA_0003, 64'hC2C2_5555_AAAA_0002,
                   64'hC1C1_5555_AAAA_0001, 64'hC0C0_5555_AAAA_0000};

        tbl[0] = mkv(1, 21'h001234, beats_a, '0, 0, 0, 4, 0, 18, 21'h001220);
        tbl[1] = mkv(0, 21'h000040, beats_b, mk(9, 10, 12, 13, -1, -1), 0, 0, 14, 0, 18, 21'h000040);
        tbl[2] = mkv(0, 21'h00005F, beats_c, mk(5, 20, -1, -1, -1, -1), 0, 0, 64, 1, 65, 21'h000040);
        tbl[3] = mkv(1, 21'h1FFFFF, beats_c, mk(1, 2, -1, -1, -1, -1), 1, 0, 4, 0, 18, 21'h1FFFE0);
        tbl[4] = mkv(0, 21'h0ABCDE, beats_a, mk(0, 1, 2, 3, 4, 5), 0, 1, 4, 0, 18, 21'h0ABCC0);
        tbl[5] = mkv(0, 21'h100000, beats_b, mk(60, 61, 62, 63, -1, -1), 0, 0, 64, 0, 65, 21'h100000);
        tbl[6] = mkv(0, 21'h000021, beats_a, mk(10, 20, 30, 64, -1, -1), 0, 1, 64, 1, 65, 21'h000020);
        tbl[7] = mkv(0, 21'h155555, beats_c, mk(1, 2, 3, 17, -1, -1), 1, 0, 18, 0, 19, 21'h155540);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset in the middle of a write burst abandons it without completion.
        line_req = 1'b1; line_we = 1'b1; line_addr = 21'h002000; line_wr_data = beats_b;
        step();
        line_req = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0, 2);
        chk("midrst_cmd_en", br_cmd_en, 0, 2);
        chk("midrst_cmd", br_cmd, 0, 2);
        chk("midrst_addr", br_addr, 0, 2);
        chk("midrst_wr_data", br_wr_data, 0, 2);
        chk("midrst_rd_data", line_rd_data, 0, 2);
        chk("midrst_error", line_error, 0, 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_done", line_done, 0, 3 + i);
        end
        rst_n = 1'b1;
        model_rd = '0;
        model_wr_last = '0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("postrst_no_done", line_done, 0, i);
            step();
        end
        run_txn(tbl[0]);
        run_txn(tbl[1]);

        // Randomized transfers against the timeline model.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                chk("gap_busy", busy, 0, g);
                chk("gap_cmd_en", br_cmd_en, 0, g);
                chk("gap_done", line_done, 0, g);
                br_rd_data_valid = 1'($urandom);
                br_rd_data       = r64();
                step();
            end
            br_rd_data_valid = 1'b0;
            case ($urandom_range(0, 3))
                0: p = 3;
                1: p = 8;
                2: p = 20;
                default: p = 60;
            endcase
            v.we     = 1'($urandom);
            v.addr   = AW'($urandom);
            v.data   = r256();
            v.hammer = ($urandom_range(0, 3) == 0);
            v.stray  = 1'($urandom);
            v.mask   = '0;
            for (int t = 0; t < NT; t++) v.mask[t] = ($urandom_range(0, 99) < p);
            v.exp_addr = v.addr & ~AW'(31);
            model(v.we, v.mask, v.done_t, v.err, v.idle_t);
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
